// File: rtl/led_trail_pwm_pkg.sv
// Shared helpers for the LED trail PWM stage.
// PWM_MAX derivation, level width, and counter width.
package led_trail_pwm_pkg;

  // Full-scale level and frame length in cycles.
  function automatic int pwm_max(input int bits);
    return (1 << bits) - 1;
  endfunction

  // Width of a level register for a given resolution.
  function automatic int level_w(input int bits);
    return bits;
  endfunction

  // Width of a counter that runs 0..n-1 (at least 1 bit).
  function automatic int cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness level, frame-aligned shadow and PWM comparator.
// Ports: clk, rst_n, in_bit, decay_tick, load_shadow, pwm_cnt, clear -> pwm_out.
module led_pwm_channel
  import led_trail_pwm_pkg::*;
#(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_STEP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_bit,
  input  logic                decay_tick,
  input  logic                load_shadow,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                clear,
  output logic                pwm_out
);

  localparam int LW = level_w(PWM_BITS);
  localparam logic [LW-1:0] LMAX = LW'(pwm_max(PWM_BITS));
  localparam logic [LW-1:0] STEP = LW'(DECAY_STEP);

  logic [LW-1:0] level_q, level_d;
  logic [LW-1:0] shadow_q, shadow_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    level_d  = level_q;
    shadow_d = shadow_q;
    pwm_d    = (shadow_q > pwm_cnt);
    if (clear) begin
      level_d  = '0;
      shadow_d = '0;
      pwm_d    = 1'b0;
    end else begin
      // A lit input beats a coincident decay tick.
      if (in_bit) begin
        level_d = LMAX;
      end else if (decay_tick) begin
        level_d = (int'(level_q) > DECAY_STEP)
                  ? level_q - STEP : '0;
      end
      // Shadow takes the pre-update level.
      if (load_shadow) begin
        shadow_d = level_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      level_q  <= level_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/led_trail_pwm.sv
// LED output stage: full-bright while lit, then a fading PWM trail.
// Ports: clk, rst_n, enable, led_in -> led_pwm, frame_start.
module led_trail_pwm
  import led_trail_pwm_pkg::*;
#(
  parameter int          LED_WIDTH  = 8,
  parameter int          PWM_BITS   = 8,
  parameter int unsigned DECAY_DIV  = 24'd1_000_000,
  parameter int          DECAY_STEP = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [LED_WIDTH-1:0] led_in,
  output logic [LED_WIDTH-1:0] led_pwm,
  output logic                 frame_start
);

  localparam int DW = cnt_w(DECAY_DIV);
  localparam logic [PWM_BITS-1:0] CNT_LAST =
    PWM_BITS'(pwm_max(PWM_BITS) - 1);
  localparam logic [DW-1:0] DEC_LAST = DW'(DECAY_DIV - 1);

  logic [LED_WIDTH-1:0] led_in_q;
  logic                 run_q, run_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [DW-1:0]        dec_cnt_q, dec_cnt_d;
  logic                 frame_q, frame_d;
  logic                 pwm_last;
  logic                 decay_tick;
  logic                 load_shadow;
  logic                 clear;
  logic [LED_WIDTH-1:0] pwm_w;

  assign pwm_last    = (pwm_cnt_q == CNT_LAST);
  assign decay_tick  = run_q & (dec_cnt_q == DEC_LAST);
  assign load_shadow = run_q & pwm_last;
  assign clear       = ~enable;

  // run_q marks cycles after the first enabled edge; that edge
  // restarts both counters at 0 and raises frame_start.
  always_comb begin
    run_d     = 1'b0;
    pwm_cnt_d = '0;
    dec_cnt_d = '0;
    frame_d   = 1'b0;
    if (enable) begin
      run_d = 1'b1;
      if (!run_q) begin
        frame_d = 1'b1;
      end else begin
        frame_d   = pwm_last;
        pwm_cnt_d = pwm_last ? '0
                  : pwm_cnt_q + PWM_BITS'(1);
        dec_cnt_d = (dec_cnt_q == DEC_LAST) ? '0
                  : dec_cnt_q + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_in_q  <= '0;
      run_q     <= 1'b0;
      pwm_cnt_q <= '0;
      dec_cnt_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      led_in_q  <= led_in;
      run_q     <= run_d;
      pwm_cnt_q <= pwm_cnt_d;
      dec_cnt_q <= dec_cnt_d;
      frame_q   <= frame_d;
    end
  end

  for (genvar i = 0; i < LED_WIDTH; i++) begin : gen_ch
    led_pwm_channel #(
      .PWM_BITS   (PWM_BITS),
      .DECAY_STEP (DECAY_STEP)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_bit      (led_in_q[i]),
      .decay_tick  (decay_tick),
      .load_shadow (load_shadow),
      .pwm_cnt     (pwm_cnt_q),
      .clear       (clear),
      .pwm_out     (pwm_w[i])
    );
  end

  assign led_pwm     = pwm_w;
  assign frame_start = frame_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm: cycle scoreboard plus per-frame duty checks.
// PWM_BITS=4 (frame 15), DECAY_DIV=30, DECAY_STEP=4.
module tb_led_trail_pwm;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] led_in;
  logic [7:0] led_pwm;
  logic       frame_start;

  int n_chk  = 0;
  int n_pass = 0;
  bit sb_on  = 1'b1;
  logic [8:0] sbq[$];

  led_trail_pwm #(
    .LED_WIDTH  (8),
    .PWM_BITS   (4),
    .DECAY_DIV  (30),
    .DECAY_STEP (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .led_in      (led_in),
    .led_pwm     (led_pwm),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the stage, one push per clock edge.
  logic [3:0] m_lvl[8];
  logic [3:0] m_sh[8];
  logic [7:0] m_in_r;
  logic [7:0] m_pwm;
  logic       m_fs;
  int         m_cnt;
  int         m_dec;
  bit         m_run;

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] np;
    bit tk;
    bit ld;
    np = '0;
    if (!rst_n) begin
      m_in_r = '0; m_pwm = '0; m_fs = 1'b0;
      m_cnt = 0; m_dec = 0; m_run = 1'b0;
      for (int i = 0; i < 8; i++) begin
        m_lvl[i] = '0; m_sh[i] = '0;
      end
    end else begin
      tk = m_run && (m_dec == 29);
      ld = m_run && (m_cnt == 14);
      if (!enable) begin
        m_pwm = '0; m_fs = 1'b0;
        m_cnt = 0; m_dec = 0; m_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
          m_lvl[i] = '0; m_sh[i] = '0;
        end
      end else begin
        for (int i = 0; i < 8; i++) begin
          np[i] = (int'(m_sh[i]) > m_cnt);
          if (ld) m_sh[i] = m_lvl[i];
          if (m_in_r[i]) m_lvl[i] = 4'd15;
          else if (tk)
            m_lvl[i] = (m_lvl[i] > 4'd4) ? m_lvl[i] - 4'd4 : 4'd0;
        end
        m_pwm = np;
        if (!m_run) begin
          m_run = 1'b1; m_cnt = 0; m_dec = 0; m_fs = 1'b1;
        end else begin
          m_fs  = (m_cnt == 14);
          m_cnt = (m_cnt == 14) ? 0 : m_cnt + 1;
          m_dec = (m_dec == 29) ? 0 : m_dec + 1;
        end
      end
      m_in_r = led_in;
      sbq.push_back({m_pwm, m_fs});
    end
  end

  always @(negedge clk) begin
    logic [8:0] e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      if (sb_on) begin
        n_chk++;
        if ({led_pwm, frame_start} !== e)
          $display("FAIL scoreboard t=%0t got pwm=%h fs=%b exp pwm=%h fs=%b",
                   $time, led_pwm, frame_start, e[8:1], e[0]);
        else
          n_pass++;
      end
    end
  end

  task automatic sync_frame;
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (frame_start !== 1'b1 && k < 40);
    if (frame_start !== 1'b1) begin
      n_chk++;
      $display("FAIL sync_frame no frame_start within 40 clk");
    end
  endtask

  // Counts on-cycles of bit b over the next 15 samples; oth counts
  // samples where any other bit was on.
  task automatic frame_count(input int b, output int c, output int oth);
    logic [7:0] m;
    m = 8'h01 << b;
    c = 0;
    oth = 0;
    repeat (15) begin
      @(negedge clk);
      if ((led_pwm & m) != 0) c++;
      if ((led_pwm & ~m) != 0) oth++;
    end
  endtask

  task automatic wait_pre_tick;
    int k;
    k = 0;
    while (m_dec != 28 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (m_dec != 28) begin
      n_chk++;
      $display("FAIL wait_pre_tick no decay tick within 40 clk");
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    enable = 1'b1;
    led_in = '0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (led_pwm !== 8'h00 || frame_start !== 1'b0)
      $display("FAIL reset_state got pwm=%h fs=%b exp pwm=00 fs=0",
               led_pwm, frame_start);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_idle;
    int last;
    int npulse;
    logic [7:0] orv;
    last = -1;
    npulse = 0;
    orv = '0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      orv |= led_pwm;
      if (frame_start === 1'b1) begin
        npulse++;
        if (last >= 0) begin
          n_chk++;
          if (k - last != 15)
            $display("FAIL fs_period got %0d exp 15", k - last);
          else n_pass++;
        end
        last = k;
      end
    end
    n_chk++;
    if (orv !== 8'h00)
      $display("FAIL idle_dark got %h exp 00", orv);
    else n_pass++;
    n_chk++;
    if (npulse != 14)
      $display("FAIL idle_pulses got %0d exp 14", npulse);
    else n_pass++;
  endtask

  task automatic test_full_on;
    int c, o;
    led_in = 8'h01;
    sync_frame();
    frame_count(0, c, o);
    frame_count(0, c, o);
    n_chk++;
    if (c != 15 || o != 0)
      $display("FAIL full_on got on=%0d others=%0d exp 15 0", c, o);
    else n_pass++;
  endtask

  task automatic test_decay;
    int c, o;
    int seq[$];
    int all[$];
    int exp5[5] = '{15, 11, 7, 3, 0};
    led_in = 8'h01;
    repeat (60) @(negedge clk);
    led_in = 8'h00;
    sync_frame();
    for (int f = 0; f < 14; f++) begin
      frame_count(0, c, o);
      all.push_back(c);
      if (seq.size() == 0 || seq[$] != c) seq.push_back(c);
    end
    n_chk++;
    if (seq.size() != 5)
      $display("FAIL decay_steps got %0d distinct exp 5", seq.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i < seq.size()) begin
        n_chk++;
        if (seq[i] != exp5[i])
          $display("FAIL decay_seq[%0d] got %0d exp %0d", i, seq[i], exp5[i]);
        else n_pass++;
      end
    end
    n_chk++;
    if (all[11] != 0 || all[12] != 0 || all[13] != 0)
      $display("FAIL decay_floor got %0d %0d %0d exp 0 0 0",
               all[11], all[12], all[13]);
    else n_pass++;
  endtask

  task automatic test_tick_collision;
    int c1, c2, o;
    led_in = 8'h08;
    repeat (45) @(negedge clk);
    led_in = 8'h00;
    wait_pre_tick();
    @(negedge clk);
    wait_pre_tick();
    led_in = 8'h08;
    @(negedge clk);
    led_in = 8'h00;
    sync_frame();
    frame_count(3, c1, o);
    frame_count(3, c2, o);
    n_chk++;
    if (c1 != 11)
      $display("FAIL collide_pre got %0d exp 11", c1);
    else n_pass++;
    n_chk++;
    if (c2 != 15)
      $display("FAIL collide_win got %0d exp 15", c2);
    else n_pass++;
  endtask

  task automatic test_walk;
    int c5, c6, c7, o;
    logic [7:0] pat[3] = '{8'h80, 8'h40, 8'h20};
    sync_frame();
    for (int p = 0; p < 3; p++) begin
      led_in = pat[p];
      repeat (60) @(negedge clk);
    end
    frame_count(5, c5, o);
    frame_count(5, c5, o);
    n_chk++;
    if (c5 != 15)
      $display("FAIL walk_cur got %0d exp 15", c5);
    else n_pass++;
    frame_count(6, c6, o);
    n_chk++;
    if (c6 != 7 && c6 != 3)
      $display("FAIL walk_prev got %0d exp 7 or 3", c6);
    else n_pass++;
    frame_count(7, c7, o);
    n_chk++;
    if (c7 != 0)
      $display("FAIL walk_old got %0d exp 0", c7);
    else n_pass++;
    led_in = 8'h00;
  endtask

  task automatic test_enable_reset;
    int c, o;
    led_in = 8'hFF;
    repeat (47) @(negedge clk);
    n_chk++;
    if (led_pwm !== 8'hFF)
      $display("FAIL pre_disable got %h exp ff", led_pwm);
    else n_pass++;
    enable = 1'b0;
    led_in = 8'h00;
    @(negedge clk);
    n_chk++;
    if (led_pwm !== 8'h00 || frame_start !== 1'b0)
      $display("FAIL disable got pwm=%h fs=%b exp 00 0", led_pwm, frame_start);
    else n_pass++;
    repeat (10) @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    n_chk++;
    if (frame_start !== 1'b1 || led_pwm !== 8'h00)
      $display("FAIL reenable got pwm=%h fs=%b exp 00 1", led_pwm, frame_start);
    else n_pass++;
    frame_count(0, c, o);
    n_chk++;
    if (c != 0 || o != 0)
      $display("FAIL reenable_dark got on=%0d others=%0d exp 0 0", c, o);
    else n_pass++;
    led_in = 8'hFF;
    repeat (52) @(negedge clk);
    n_chk++;
    if (led_pwm !== 8'hFF)
      $display("FAIL pre_reset got %h exp ff", led_pwm);
    else n_pass++;
    @(posedge clk);
    #3;
    sb_on = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (led_pwm !== 8'h00 || frame_start !== 1'b0)
      $display("FAIL async_reset got pwm=%h fs=%b exp 00 0",
               led_pwm, frame_start);
    else n_pass++;
    led_in = 8'h01;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    sb_on = 1'b1;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_full_on();
    test_decay();
    test_tick_collision();
    test_walk();
    test_enable_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
